// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter: op encodings, FSM states and op legality.
package shift_pkg;

    typedef enum logic [2:0] {
        OpShl  = 3'd0,
        OpShr  = 3'd1,
        OpShra = 3'd2,
        OpRol  = 3'd3,
        OpRor  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

    function automatic logic is_illegal_op(input logic [2:0] op);
        return op > 3'd4;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate of a value by a small count (at most STEP positions).
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 6
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] shifted
);

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rol_v;
    logic [2*WIDTH-1:0] ror_v;

    // Rotates use a doubled copy so the wrapped-out bits reappear in the kept half.
    always_comb begin
        dbl   = {value, value};
        rol_v = dbl << count;
        ror_v = dbl >> count;
        shifted = value;
        case (op)
            OpShl:   shifted = value << count;
            OpShr:   shifted = value >> count;
            OpShra:  shifted = $unsigned($signed(value) >>> count);
            OpRol:   shifted = rol_v[2*WIDTH-1:WIDTH];
            OpRor:   shifted = ror_v[WIDTH-1:0];
            default: shifted = value;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: captures a request, shifts up to STEP bits per clock,
// then pulses done for one cycle.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] amount,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned LOG_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W  = LOG_W + 1;
    localparam int unsigned STEP_W = $clog2(STEP + 1);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               err_q, err_d;

    logic [CNT_W-1:0]   k;
    logic [STEP_W-1:0]  step_cnt;
    logic [WIDTH-1:0]   stepped;
    logic               illegal;

    // Effective count: shifts saturate at WIDTH, rotates wrap modulo WIDTH.
    always_comb begin
        illegal = is_illegal_op(op);
        if (op == OpRol || op == OpRor) begin
            k = {1'b0, amount[LOG_W-1:0]};
        end else if (amount >= WIDTH_V) begin
            k = CNT_W'(WIDTH);
        end else begin
            k = amount[CNT_W-1:0];
        end
    end

    always_comb begin
        if (rem_q >= CNT_W'(STEP)) begin
            step_cnt = STEP_W'(STEP);
        end else begin
            step_cnt = rem_q[STEP_W-1:0];
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .CW    (STEP_W)
    ) u_step (
        .value   (result_q),
        .op      (op_q),
        .count   (step_cnt),
        .shifted (stepped)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rem_d    = rem_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d     = op;
                    result_d = operand;
                    err_d    = illegal;
                    if (illegal) begin
                        rem_d   = '0;
                        state_d = StFin;
                    end else begin
                        rem_d   = k;
                        state_d = (k == '0) ? StFin : StRun;
                    end
                end
            end
            StRun: begin
                result_d = stepped;
                rem_d    = rem_q - CNT_W'(step_cnt);
                if (rem_q <= CNT_W'(STEP)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= StIdle;
            op_q     <= '0;
            rem_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StFin);
    assign err    = err_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench: three shifters (STEP 1, 4, 8) share inputs; a monitor checks every done.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        clr;
    logic [2:0]  op;
    logic [31:0] operand;
    logic [31:0] amount;
    logic        st  [3];
    logic [31:0] res [3];
    logic        bsy [3];
    logic        dn  [3];
    logic        er  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned STEP_G = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        seq_shifter #(
            .WIDTH (32),
            .STEP  (STEP_G)
        ) u_dut (
            .clk     (clk),
            .clr     (clr),
            .start   (st[g]),
            .op      (op),
            .operand (operand),
            .amount  (amount),
            .result  (res[g]),
            .busy    (bsy[g]),
            .done    (dn[g]),
            .err     (er[g])
        );
    end

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
        int          lat;
        int          e0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dn[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_done: got done on dut %0d, expected none", i);
                end else begin
                    mon_e = sb.pop_front();
                    check32("dut_idx", 32'(i), 32'(mon_e.idx));
                    check32("result", res[i], mon_e.res);
                    check32("err", 32'(er[i]), 32'(mon_e.err));
                    check32("latency", 32'(cyc - mon_e.e0), 32'(mon_e.lat));
                end
            end
        end
    end

    // Drive a request at the current negedge and record what it must produce.
    task automatic launch(input int idx, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic e,
                          input int lat);
        exp_t x;
        op = o;
        operand = a;
        amount = b;
        st[idx] = 1'b1;
        x.idx = idx;
        x.res = r;
        x.err = e;
        x.lat = lat;
        x.e0  = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic wait_idle(input int idx);
        int t = 0;
        while (bsy[idx] === 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check32("idle_timeout", 32'(t >= 200), 32'd0);
    endtask

    // Launch, drop start, scramble the inputs (must not matter), wait for completion.
    task automatic issue(input int idx, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic e,
                         input int lat);
        @(negedge clk);
        launch(idx, o, a, b, r, e, lat);
        @(negedge clk);
        st[idx] = 1'b0;
        op = 3'd3;
        operand = $urandom;
        amount = $urandom;
        wait_idle(idx);
    endtask

    initial begin
        int t;
        clr = 1'b0;
        op = 3'd0;
        operand = '0;
        amount = '0;
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        #2 clr = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check32("rst_result", res[i], 32'd0);
            check32("rst_busy", 32'(bsy[i]), 32'd0);
            check32("rst_done", 32'(dn[i]), 32'd0);
            check32("rst_err", 32'(er[i]), 32'd0);
        end
        @(negedge clk);
        clr = 1'b0;

        issue(0, 3'd0, 32'h0000_0003, 32'd2,   32'h0000_000C, 1'b0, 2);
        issue(1, 3'd2, 32'h8000_0000, 32'd4,   32'hF800_0000, 1'b0, 1);
        issue(0, 3'd4, 32'h0000_0001, 32'd33,  32'h8000_0000, 1'b0, 1);
        issue(1, 3'd3, 32'h1234_5678, 32'd32,  32'h1234_5678, 1'b0, 0);
        issue(2, 3'd0, 32'hFFFF_FFFF, 32'd40,  32'h0000_0000, 1'b0, 4);
        issue(0, 3'd7, 32'hDEAD_BEEF, 32'd5,   32'hDEAD_BEEF, 1'b1, 0);
        issue(0, 3'd0, 32'h0000_0001, 32'd1,   32'h0000_0002, 1'b0, 1);
        issue(2, 3'd1, 32'hF000_0000, 32'd12,  32'h000F_0000, 1'b0, 2);
        issue(1, 3'd2, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 1'b0, 8);
        issue(2, 3'd3, 32'h8000_0001, 32'd9,   32'h0000_0300, 1'b0, 2);
        issue(1, 3'd1, 32'h1234_5678, 32'd0,   32'h1234_5678, 1'b0, 0);
        issue(0, 3'd2, 32'h4000_0000, 32'd3,   32'h0800_0000, 1'b0, 3);
        issue(1, 3'd4, 32'h1234_5678, 32'd36,  32'h8123_4567, 1'b0, 1);
        issue(2, 3'd5, 32'h0000_00A5, 32'd1,   32'h0000_00A5, 1'b1, 0);
        issue(2, 3'd1, 32'hFFFF_FFFF, 32'd32,  32'h0000_0000, 1'b0, 4);

        // Abort mid-RUN: outputs clear at once and the aborted op never reports done.
        @(negedge clk);
        launch(0, 3'd0, 32'h0000_0001, 32'd20, 32'h0010_0000, 1'b0, 20);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (4) @(negedge clk);
        #1 clr = 1'b1;
        #1;
        void'(sb.pop_back());
        check32("clr_result", res[0], 32'd0);
        check32("clr_busy", 32'(bsy[0]), 32'd0);
        check32("clr_done", 32'(dn[0]), 32'd0);
        check32("clr_err", 32'(er[0]), 32'd0);
        // Start together with clr release: accepted on the very next edge.
        @(negedge clk);
        clr = 1'b0;
        launch(0, 3'd0, 32'h0000_0005, 32'd4, 32'h0000_0050, 1'b0, 4);
        @(negedge clk);
        st[0] = 1'b0;
        wait_idle(0);

        // Start while busy (in RUN and in FIN) is ignored.
        @(negedge clk);
        launch(0, 3'd0, 32'h0000_0003, 32'd10, 32'h0000_0C00, 1'b0, 10);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        op = 3'd1;
        operand = 32'hFFFF_FFFF;
        amount = 32'd1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        t = 0;
        while (dn[0] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check32("fin_timeout", 32'(t >= 100), 32'd0);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        check32("fin_start_ignored", 32'(bsy[0]), 32'd0);
        check32("held_result", res[0], 32'h0000_0C00);

        repeat (5) @(negedge clk);
        check32("pending", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; power of two, 8..64.
REQ-002 SHALL have parameter STEP, default 1, maximum bit positions shifted per clock; 1..WIDTH.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-006 SHALL have port op, input, 3, operation: 0 SHL, 1 SHR, 2 SHRA, 3 ROL, 4 ROR, 5..7 illegal.
REQ-007 SHALL have port operand, input, WIDTH, value to shift (register source).
REQ-008 SHALL have port amount, input, WIDTH, shift count (Y register source), unsigned.
REQ-009 SHALL have port result, output, WIDTH, shifted value; held until the next accepted start.
REQ-010 SHALL have port busy, output, 1, high in RUN and FIN.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse, high exactly while in FIN.
REQ-012 SHALL have port err, output, 1, illegal op flag; valid with done, held until the next accepted start.

Function
REQ-013 SHALL implement states IDLE, RUN, FIN; FIN always returns to IDLE after one cycle.
REQ-014 SHALL capture op, operand, and amount at accepting edge E0 (IDLE, start=1); result loads operand at E0.
REQ-015 SHALL compute effective count k: shifts k=min(amount,WIDTH); rotates k=amount mod WIDTH.
REQ-016 SHALL define n=ceil(k/STEP); at E0 go to RUN if n>0, else directly to FIN.
REQ-017 SHALL shift result by min(STEP, remaining) at each RUN edge and decrement remaining; enter FIN at edge E0+n.
REQ-018 SHALL assert done during [E0+n, E0+n+1) only; total latency from start edge to done equals n.
REQ-019 SHALL fill vacated bits: SHL/SHR with zero, SHRA with operand MSB; rotates lose no bits.
REQ-020 SHALL give SHL/SHR a result of 0 when amount>=WIDTH, and SHRA all-sign when amount>=WIDTH.
REQ-021 SHALL, on illegal op, go from IDLE to FIN at E0 with err=1 and result=operand.
REQ-022 SHALL ignore start while busy=1, including in FIN; captured inputs are not disturbed.
REQ-023 SHALL ignore input changes after E0; only the captured copies are used.

Reset
REQ-024 SHALL, while clr=1, force state IDLE, result=0, busy=0, done=0, err=0, and remaining count=0, independent of clk.
REQ-025 SHALL abort an operation when clr is asserted in RUN or FIN; no done pulse follows, and a new start is accepted on the first edge after clr deasserts.

Structure
REQ-026 SHALL take op encodings, the state enumeration, and the illegal-op check function from shared package shift_pkg.
REQ-027 SHALL use one combinational sub-module shift_step (inputs value, op, count<=STEP; output the value shifted once) instantiated once.
REQ-028 SHALL size the remaining-count register at clog2(WIDTH)+1 bits.

Verification (WIDTH=32)
REQ-029 SHALL check: STEP=1, SHL 0x00000003 by 2 -> done at E0+2, result 0x0000000C, err=0.
REQ-030 SHALL check: STEP=4, SHRA 0x80000000 by 4 -> done at E0+1, result 0xF8000000.
REQ-031 SHALL check: ROR 0x00000001 by 33 -> 0x80000000 (k=1); ROL 0x12345678 by 32 -> done at E0, result 0x12345678.
REQ-032 SHALL check: STEP=8, SHL 0xFFFFFFFF by 40 -> result 0x00000000, done at E0+4.
REQ-033 SHALL check: clr pulsed mid-RUN -> all outputs 0, no done; start pulsed while busy -> ignored, and the original result completes.
REQ-034 SHALL check: op=7, operand 0xDEADBEEF -> done at E0, err=1, result 0xDEADBEEF.
